// File: rtl/inst_assemble_pkg.sv
// Shared encodings for the instruction byte-assembly stage.
// Holds the opcode class codes, instruction lengths and the assembly FSM states.
package inst_assemble_pkg;

    localparam logic [1:0] CLS_ALU  = 2'b00;
    localparam logic [1:0] CLS_IMM  = 2'b01;
    localparam logic [1:0] CLS_JMP  = 2'b10;
    localparam logic [1:0] CLS_EXT  = 2'b11;
    localparam logic [1:0] RSVD_SUB = 2'b11;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

    typedef enum logic [1:0] {
        S_OP = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } state_e;

endpackage

// File: rtl/inst_len_decode.sv
// Combinational length/legality decode of an opcode byte.
// A reserved ext sub-opcode is reported as illegal and treated as a single byte.
module inst_len_decode
    import inst_assemble_pkg::*;
(
    input  logic [7:0] byte0_i,
    output logic [1:0] len_o,
    output logic       illegal_o
);

    always_comb begin
        len_o     = LEN_1;
        illegal_o = 1'b0;
        unique case (byte0_i[7:6])
            CLS_ALU: len_o = LEN_1;
            CLS_IMM: len_o = LEN_2;
            CLS_JMP: len_o = LEN_2;
            CLS_EXT: begin
                if (byte0_i[5:4] == RSVD_SUB) begin
                    len_o     = LEN_1;
                    illegal_o = 1'b1;
                end else begin
                    len_o = LEN_3;
                end
            end
            default: len_o = LEN_1;
        endcase
    end

endmodule

// File: rtl/inst_assemble.sv
// Collects 1-3 instruction bytes from fetch and presents one decoded instruction
// with its start PC to the control unit through a valid/ready handshake.
module inst_assemble
    import inst_assemble_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              byte_valid,
    input  logic [DATA_W-1:0] byte_in,
    input  logic [ADDR_W-1:0] byte_pc,
    output logic              byte_ready,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_opcode,
    output logic [1:0]        dec_len,
    output logic [DATA_W-1:0] dec_imm,
    output logic [ADDR_W-1:0] dec_addr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              dec_illegal
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] op_q, op_d, b1_q, b1_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]        len_q, len_d;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] out_op_q, out_op_d, out_imm_q, out_imm_d;
    logic [1:0]        out_len_q, out_len_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d, out_pc_q, out_pc_d;
    logic              out_ill_q, out_ill_d;

    logic       accept, issue;
    logic [1:0] dl;
    logic       dil;

    inst_len_decode u_len (
        .byte0_i   (byte_in),
        .len_o     (dl),
        .illegal_o (dil)
    );

    assign byte_ready = !valid_q | dec_ready;
    assign accept     = byte_valid & byte_ready & !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_OP;
            op_q       <= '0;
            b1_q       <= '0;
            pc_q       <= '0;
            len_q      <= '0;
            valid_q    <= 1'b0;
            out_op_q   <= '0;
            out_len_q  <= '0;
            out_imm_q  <= '0;
            out_addr_q <= '0;
            out_pc_q   <= '0;
            out_ill_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            b1_q       <= b1_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            valid_q    <= valid_d;
            out_op_q   <= out_op_d;
            out_len_q  <= out_len_d;
            out_imm_q  <= out_imm_d;
            out_addr_q <= out_addr_d;
            out_pc_q   <= out_pc_d;
            out_ill_q  <= out_ill_d;
        end
    end

    // The issuing byte is taken straight from byte_in so the output register
    // loads in the same cycle the final byte is accepted.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        b1_d       = b1_q;
        pc_d       = pc_q;
        len_d      = len_q;
        issue      = 1'b0;
        out_op_d   = out_op_q;
        out_len_d  = out_len_q;
        out_imm_d  = out_imm_q;
        out_addr_d = out_addr_q;
        out_pc_d   = out_pc_q;
        out_ill_d  = out_ill_q;
        if (flush) begin
            state_d = S_OP;
        end else if (accept) begin
            unique case (state_q)
                S_OP: begin
                    op_d  = byte_in;
                    pc_d  = byte_pc;
                    len_d = dl;
                    if (dl == LEN_1) begin
                        issue      = 1'b1;
                        out_op_d   = byte_in;
                        out_len_d  = LEN_1;
                        out_imm_d  = '0;
                        out_addr_d = '0;
                        out_pc_d   = byte_pc;
                        out_ill_d  = dil;
                    end else begin
                        state_d = S_B1;
                    end
                end
                S_B1: begin
                    if (len_q == LEN_2) begin
                        issue      = 1'b1;
                        state_d    = S_OP;
                        out_op_d   = op_q;
                        out_len_d  = LEN_2;
                        out_pc_d   = pc_q;
                        out_ill_d  = 1'b0;
                        out_imm_d  = '0;
                        out_addr_d = '0;
                        if (op_q[7:6] == CLS_IMM) out_imm_d = byte_in;
                        else out_addr_d = ADDR_W'({op_q[3:0], byte_in});
                    end else begin
                        b1_d    = byte_in;
                        state_d = S_B2;
                    end
                end
                S_B2: begin
                    issue      = 1'b1;
                    state_d    = S_OP;
                    out_op_d   = op_q;
                    out_len_d  = LEN_3;
                    out_imm_d  = b1_q;
                    out_addr_d = ADDR_W'({op_q[3:0], byte_in});
                    out_pc_d   = pc_q;
                    out_ill_d  = 1'b0;
                end
                default: state_d = S_OP;
            endcase
        end
        if (flush)                  valid_d = 1'b0;
        else if (issue)             valid_d = 1'b1;
        else if (valid_q & dec_ready) valid_d = 1'b0;
        else                        valid_d = valid_q;
    end

    assign dec_valid   = valid_q;
    assign dec_opcode  = out_op_q;
    assign dec_len     = out_len_q;
    assign dec_imm     = out_imm_q;
    assign dec_addr    = out_addr_q;
    assign dec_pc      = out_pc_q;
    assign dec_illegal = out_ill_q;

endmodule

// File: tb/tb_inst_assemble.sv
// Scoreboard bench for inst_assemble: expected decodes are queued as bytes are
// driven, the monitor queues every consumed instruction, each test compares both.
module tb_inst_assemble;
    import inst_assemble_pkg::*;

    typedef struct packed {
        logic [7:0]  op;
        logic [1:0]  len;
        logic [7:0]  imm;
        logic [11:0] addr;
        logic [11:0] pc;
        logic        ill;
    } dec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_in = '0;
    logic [11:0] byte_pc = '0;
    logic        byte_ready;
    logic        dec_valid;
    logic        dec_ready = 1'b1;
    logic [7:0]  dec_opcode;
    logic [1:0]  dec_len;
    logic [7:0]  dec_imm;
    logic [11:0] dec_addr;
    logic [11:0] dec_pc;
    logic        dec_illegal;

    int   n_checks = 0;
    int   n_fail   = 0;
    dec_t exp_q[$];
    dec_t obs_q[$];

    inst_assemble #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .byte_pc     (byte_pc),
        .byte_ready  (byte_ready),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_opcode  (dec_opcode),
        .dec_len     (dec_len),
        .dec_imm     (dec_imm),
        .dec_addr    (dec_addr),
        .dec_pc      (dec_pc),
        .dec_illegal (dec_illegal)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so negedge sees the handshake that the next posedge takes.
    always @(negedge clk) begin
        if (!reset && !flush && dec_valid && dec_ready)
            obs_q.push_back('{dec_opcode, dec_len, dec_imm, dec_addr, dec_pc, dec_illegal});
    end

    task automatic put(input logic [7:0] b, input logic [11:0] pc);
        int unsigned waited = 0;
        byte_valid = 1'b1;
        byte_in    = b;
        byte_pc    = pc;
        @(negedge clk);
        while (!byte_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!byte_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL put_timeout byte=%h: byte_ready=%b, required 1", b, byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_checks++;
        if ({dec_valid, byte_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_ctrl: valid/ready=%b, required 01", {dec_valid, byte_ready});
        end
        n_checks++;
        if ({dec_opcode, dec_len, dec_imm, dec_addr, dec_pc, dec_illegal} !== 43'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got %h, required 0",
                     {dec_opcode, dec_len, dec_imm, dec_addr, dec_pc, dec_illegal});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        dec_t e, o;
        dec_ready = 1'b1;
        exp_q.push_back('{8'h12, 2'd1, 8'h00, 12'h000, 12'h000, 1'b0});
        exp_q.push_back('{8'h05, 2'd1, 8'h00, 12'h000, 12'h001, 1'b0});
        put(8'h12, 12'h000);
        n_checks++;
        if ({dec_valid, dec_opcode} !== {1'b1, 8'h12}) begin
            n_fail++;
            $display("FAIL b2b_first: valid/op=%h, required 112", {dec_valid, dec_opcode});
        end
        put(8'h05, 12'h001);
        n_checks++;
        if ({dec_valid, dec_opcode} !== {1'b1, 8'h05}) begin
            n_fail++;
            $display("FAIL b2b_second: valid/op=%h, required 105", {dec_valid, dec_opcode});
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_decode: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_multi_byte;
        dec_t e, o;
        exp_q.push_back('{8'h4A, 2'd2, 8'h7F, 12'h000, 12'h020, 1'b0});
        put(8'h4A, 12'h020);
        put(8'h7F, 12'h021);
        exp_q.push_back('{8'h83, 2'd2, 8'h00, 12'h321, 12'h010, 1'b0});
        put(8'h83, 12'h010);
        put(8'h21, 12'h011);
        exp_q.push_back('{8'hC5, 2'd3, 8'h99, 12'h5AB, 12'h030, 1'b0});
        put(8'hC5, 12'h030);
        put(8'h99, 12'h031);
        put(8'hAB, 12'h032);
        exp_q.push_back('{8'hF0, 2'd1, 8'h00, 12'h000, 12'h033, 1'b1});
        put(8'hF0, 12'h033);
        exp_q.push_back('{8'h9F, 2'd2, 8'h00, 12'hFFF, 12'hFFE, 1'b0});
        put(8'h9F, 12'hFFE);
        put(8'hFF, 12'hFFF);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL multi_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL multi_decode: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_backpressure;
        dec_t e, o;
        dec_ready = 1'b1;
        exp_q.push_back('{8'h12, 2'd1, 8'h00, 12'h000, 12'h040, 1'b0});
        put(8'h12, 12'h040);
        dec_ready  = 1'b0;
        byte_valid = 1'b1;
        byte_in    = 8'h4A;
        byte_pc    = 12'h041;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({byte_ready, dec_valid, dec_opcode, dec_pc} !== {1'b0, 1'b1, 8'h12, 12'h040}) begin
                n_fail++;
                $display("FAIL stall_hold: rdy/valid/op/pc=%h, required 112040",
                         {byte_ready, dec_valid, dec_opcode, dec_pc});
            end
        end
        @(posedge clk);
        #1;
        dec_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (byte_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: byte_ready=%b, required 1", byte_ready);
        end
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        exp_q.push_back('{8'h4A, 2'd2, 8'h7F, 12'h000, 12'h041, 1'b0});
        put(8'h7F, 12'h042);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL stall_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL stall_decode: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_flush;
        dec_t e, o;
        dec_ready = 1'b1;
        put(8'hC5, 12'h050);
        put(8'h99, 12'h051);
        flush      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'hAB;
        byte_pc    = 12'h052;
        @(posedge clk);
        #1;
        flush      = 1'b0;
        byte_valid = 1'b0;
        n_checks++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_final: dec_valid=%b, required 0", dec_valid);
        end
        exp_q.push_back('{8'h01, 2'd1, 8'h00, 12'h000, 12'h060, 1'b0});
        put(8'h01, 12'h060);
        repeat (2) @(posedge clk);
        #1;
        dec_ready = 1'b0;
        put(8'h12, 12'h070);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_checks++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_held: dec_valid=%b, required 0", dec_valid);
        end
        dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL flush_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL flush_decode: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_async_reset;
        dec_t e, o;
        dec_ready = 1'b0;
        put(8'h05, 12'h080);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({dec_valid, dec_opcode, byte_ready} !== {1'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL areset_valid: valid/op/rdy=%h, required 001",
                     {dec_valid, dec_opcode, byte_ready});
        end
        @(posedge clk);
        #1;
        reset     = 1'b0;
        dec_ready = 1'b1;
        put(8'h83, 12'h090);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut.state_q !== S_OP) begin
            n_fail++;
            $display("FAIL areset_state: state=%0d, required %0d", dut.state_q, S_OP);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.push_back('{8'h21, 2'd1, 8'h00, 12'h000, 12'h091, 1'b0});
        put(8'h21, 12'h091);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL areset_count: got %0d, required %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL areset_decode: got %h, required %h", o, e);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_multi_byte();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
